// File: rtl/share_serpar_pkg.sv
// rtl/share_serpar_pkg.sv - shared romulus defaults and width helpers for the tweak/key serial-parallel block
package share_serpar_pkg;
   localparam int PDI_W_DEF  = 32;
   localparam int BLK_W_DEF  = 128;
   localparam int SHARES_DEF = 2;

   function automatic int words(input int blk_w, input int pdi_w);
      return blk_w / pdi_w;
   endfunction

   function automatic int sel_w(input int shares);
      return (shares > 1) ? $clog2(shares) : 1;
   endfunction

   // Counter must represent 0..words inclusive.
   function automatic int cnt_w(input int nwords);
      return $clog2(nwords + 1);
   endfunction
endpackage

// File: rtl/share_serpar_if.sv
// rtl/share_serpar_if.sv - serial word handshake with target share select
interface share_serpar_if
   import share_serpar_pkg::*;
#(
   parameter int PDI_W = PDI_W_DEF,
   parameter int SEL_W = sel_w(SHARES_DEF)
);
   logic [PDI_W-1:0] pdi;
   logic             pdi_valid;
   logic             pdi_ready;
   logic [SEL_W-1:0] share_sel;

   modport master (output pdi, output pdi_valid, output share_sel, input pdi_ready);
   modport slave  (input pdi, input pdi_valid, input share_sel, output pdi_ready);
endinterface

// File: rtl/share_serpar_lane.sv
// rtl/share_serpar_lane.sv - one share: shift buffer, saturating word counter, full flag
module serpar_lane
   import share_serpar_pkg::*;
#(
   parameter int PDI_W = PDI_W_DEF,
   parameter int BLK_W = BLK_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wr,
   input  logic             ld,
   input  logic [PDI_W-1:0] pdi,
   input  logic [BLK_W-1:0] ld_data,
   output logic [BLK_W-1:0] data,
   output logic             full
);
   localparam int WORDS = words(BLK_W, PDI_W);
   localparam int CNT_W = cnt_w(WORDS);

   logic [BLK_W-1:0] data_q;
   logic [BLK_W-1:0] shifted;
   logic [CNT_W-1:0] cnt_q;

   generate
      if (WORDS == 1) begin : g_single
         assign shifted = pdi;
      end else begin : g_shift
         assign shifted = {data_q[BLK_W-PDI_W-1:0], pdi};
      end
   endgenerate

   assign full = (cnt_q == CNT_W'(WORDS));
   assign data = data_q;

   // The !full guard keeps the counter saturated even if wr is misused upstream.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (wr && !full) begin
         data_q <= shifted;
         cnt_q  <= cnt_q + CNT_W'(1);
      end else if (ld) begin
         data_q <= ld_data;
         cnt_q  <= CNT_W'(WORDS);
      end
   end
endmodule

// File: rtl/share_serpar.sv
// rtl/share_serpar.sv - masked tweak/key share buffer fed serially or loaded in parallel
module share_serpar
   import share_serpar_pkg::*;
#(
   parameter int PDI_W  = PDI_W_DEF,
   parameter int BLK_W  = BLK_W_DEF,
   parameter int SHARES = SHARES_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   share_serpar_if.slave           pdi_if,
   input  logic [SHARES*BLK_W-1:0] data_core,
   input  logic [SHARES*BLK_W-1:0] data_mode,
   input  logic                    en,
   input  logic                    crct,
   input  logic                    clr,
   output logic [SHARES*BLK_W-1:0] key,
   output logic [SHARES-1:0]       full,
   output logic                    key_valid,
   output logic                    done
);
   localparam int SEL_W = sel_w(SHARES);

   logic                    sel_ok;
   logic                    sel_full;
   logic                    accept;
   logic                    ld_core;
   logic                    ld_mode;
   logic                    ld;
   logic [SHARES*BLK_W-1:0] ld_data;
   logic                    kv_q;
   logic                    done_q;

   always_comb begin
      sel_ok   = ({1'b0, pdi_if.share_sel} < (SEL_W + 1)'(SHARES));
      sel_full = 1'b0;
      for (int s = 0; s < SHARES; s++) begin
         if (pdi_if.share_sel == SEL_W'(s)) sel_full = full[s];
      end
   end

   assign pdi_if.pdi_ready = rst_n && !clr && sel_ok && !sel_full;
   assign accept           = pdi_if.pdi_valid && pdi_if.pdi_ready;

   // Priority clr > accept > en > crct: a lower event is dropped, not deferred.
   assign ld_core = en && !clr && !accept;
   assign ld_mode = crct && !en && !clr && !accept;
   assign ld      = ld_core || ld_mode;
   assign ld_data = ld_core ? data_core : data_mode;

   genvar s;
   generate
      for (s = 0; s < SHARES; s++) begin : g_lane
         serpar_lane #(
            .PDI_W (PDI_W),
            .BLK_W (BLK_W)
         ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (clr),
            .wr      (accept && (pdi_if.share_sel == SEL_W'(s))),
            .ld      (ld),
            .pdi     (pdi_if.pdi),
            .ld_data (ld_data[s*BLK_W +: BLK_W]),
            .data    (key[s*BLK_W +: BLK_W]),
            .full    (full[s])
         );
      end
   endgenerate

   assign key_valid = &full;
   assign done      = done_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         kv_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         kv_q   <= key_valid;
         done_q <= key_valid && !kv_q;
      end
   end
endmodule

// File: tb/tb_share_serpar.sv
// tb/tb_share_serpar.sv - table-driven scoreboard bench for share_serpar
module tb_share_serpar;
   localparam int PDI_W = 32;
   localparam int BLK_W = 128;
   localparam int KW    = 2 * BLK_W;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [KW-1:0] data_core, data_mode;
   logic          en, crct, clr;
   logic [KW-1:0] key;
   logic [1:0]    full;
   logic          key_valid, done;

   always #5 clk = ~clk;

   share_serpar_if #(.PDI_W(PDI_W), .SEL_W(1)) pif ();

   share_serpar #(.PDI_W(PDI_W), .BLK_W(BLK_W), .SHARES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pdi_if    (pif),
      .data_core (data_core),
      .data_mode (data_mode),
      .en        (en),
      .crct      (crct),
      .clr       (clr),
      .key       (key),
      .full      (full),
      .key_valid (key_valid),
      .done      (done)
   );

   typedef struct packed {
      logic        sel;
      logic        valid;
      logic [31:0] pdi;
      logic        en;
      logic        crct;
      logic        clr;
      logic [7:0]  core_b;
      logic [7:0]  mode_b;
      logic [1:0]  exp_full;
   } vec_t;

   typedef struct {
      logic [KW-1:0] key;
      logic [1:0]    full;
      logic          kv;
      logic          done;
   } exp_t;

   exp_t         sbq[$];
   logic [127:0] m_buf [2];
   int           m_cnt [2];
   logic         m_kv_q;
   int           checks = 0;
   int           errors = 0;
   vec_t         tbl [19];

   function automatic vec_t mk(logic sel, logic valid, logic [31:0] pdi, logic e, logic c,
                               logic cl, logic [7:0] cb, logic [7:0] mb, logic [1:0] ef);
      vec_t v;
      v.sel = sel; v.valid = valid; v.pdi = pdi; v.en = e; v.crct = c; v.clr = cl;
      v.core_b = cb; v.mode_b = mb; v.exp_full = ef;
      return v;
   endfunction

   task automatic chk(string name, logic [KW-1:0] act, logic [KW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_buf[0] = '0; m_buf[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0; m_kv_q = 1'b0;
   endtask

   // Drives one cycle, predicts its effect from the priority rules, then checks after the edge.
   task automatic drive(vec_t v, string name);
      exp_t e;
      logic ready, kv_now;
      int   s;
      s = int'(v.sel);
      pif.share_sel = v.sel; pif.pdi_valid = v.valid; pif.pdi = v.pdi;
      en = v.en; crct = v.crct; clr = v.clr;
      data_core = {32{v.core_b}}; data_mode = {32{v.mode_b}};
      #1;
      ready = !v.clr && (m_cnt[s] != 4);
      chk({name, " ready"}, KW'(pif.pdi_ready), KW'(ready));
      kv_now = (m_cnt[0] == 4) && (m_cnt[1] == 4);
      e.done = kv_now && !m_kv_q;
      m_kv_q = kv_now;
      if (v.clr) begin
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (v.valid && ready) begin
         m_buf[s] = {m_buf[s][95:0], v.pdi};
         m_cnt[s]++;
      end else if (v.en) begin
         m_buf[0] = {16{v.core_b}}; m_buf[1] = {16{v.core_b}};
         m_cnt[0] = 4; m_cnt[1] = 4;
      end else if (v.crct) begin
         m_buf[0] = {16{v.mode_b}}; m_buf[1] = {16{v.mode_b}};
         m_cnt[0] = 4; m_cnt[1] = 4;
      end
      e.key  = {m_buf[1], m_buf[0]};
      e.full = {m_cnt[1] == 4, m_cnt[0] == 4};
      e.kv   = &e.full;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk({name, " key"}, key, e.key);
      chk({name, " full"}, KW'(full), KW'(e.full));
      chk({name, " full_tbl"}, KW'(full), KW'(v.exp_full));
      chk({name, " key_valid"}, KW'(key_valid), KW'(e.kv));
      chk({name, " done"}, KW'(done), KW'(e.done));
   endtask

   initial begin
      tbl[0]  = mk(0, 1, 32'h00010203, 0, 0, 0, 8'h00, 8'h00, 2'b00);
      tbl[1]  = mk(0, 1, 32'h04050607, 0, 0, 0, 8'h00, 8'h00, 2'b00);
      tbl[2]  = mk(0, 1, 32'h08090A0B, 0, 0, 0, 8'h00, 8'h00, 2'b00);
      tbl[3]  = mk(0, 1, 32'h0C0D0E0F, 0, 0, 0, 8'h00, 8'h00, 2'b01);
      tbl[4]  = mk(0, 1, 32'hFFFFFFFF, 0, 0, 0, 8'h00, 8'h00, 2'b01);
      tbl[5]  = mk(1, 1, 32'h10111213, 0, 0, 0, 8'h00, 8'h00, 2'b01);
      tbl[6]  = mk(1, 1, 32'h14151617, 0, 0, 0, 8'h00, 8'h00, 2'b01);
      tbl[7]  = mk(1, 1, 32'h18191A1B, 0, 0, 0, 8'h00, 8'h00, 2'b01);
      tbl[8]  = mk(1, 1, 32'h1C1D1E1F, 0, 0, 0, 8'h00, 8'h00, 2'b11);
      tbl[9]  = mk(0, 0, 32'h0,        0, 0, 0, 8'h00, 8'h00, 2'b11);
      tbl[10] = mk(0, 0, 32'h0,        0, 0, 0, 8'h00, 8'h00, 2'b11);
      tbl[11] = mk(1, 1, 32'h99999999, 1, 0, 1, 8'h77, 8'h00, 2'b00);
      tbl[12] = mk(1, 1, 32'hDEADBEEF, 1, 0, 0, 8'h55, 8'h00, 2'b00);
      tbl[13] = mk(0, 0, 32'h0,        1, 0, 0, 8'hA5, 8'h00, 2'b11);
      tbl[14] = mk(0, 0, 32'h0,        0, 1, 0, 8'h00, 8'h3C, 2'b11);
      tbl[15] = mk(0, 0, 32'h0,        1, 1, 0, 8'h5A, 8'hC3, 2'b11);
      tbl[16] = mk(0, 1, 32'h12345678, 0, 1, 0, 8'h00, 8'h3C, 2'b11);
      tbl[17] = mk(0, 0, 32'h0,        0, 1, 1, 8'h00, 8'h81, 2'b00);
      tbl[18] = mk(0, 0, 32'h0,        0, 1, 0, 8'h00, 8'h96, 2'b11);

      rst_n = 1'b0; en = 0; crct = 0; clr = 0; data_core = '0; data_mode = '0;
      pif.share_sel = 1'b0; pif.pdi_valid = 1'b0; pif.pdi = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("reset key", key, '0);
      chk("reset full", KW'(full), KW'(2'b00));
      chk("reset key_valid", KW'(key_valid), KW'(1'b0));
      chk("reset ready", KW'(pif.pdi_ready), KW'(1'b1));

      for (int i = 0; i < 19; i++) begin
         drive(tbl[i], $sformatf("vec%0d", i));
         if (i == 3) begin
            chk("share0 fill", KW'(key[127:0]), KW'(128'h000102030405060708090A0B0C0D0E0F));
            chk("share0 done low", KW'(done), KW'(1'b0));
         end
         if (i == 8) chk("kv after fill", KW'(key_valid), KW'(1'b1));
         if (i == 9) chk("done pulse", KW'(done), KW'(1'b1));
         if (i == 10) chk("done drop", KW'(done), KW'(1'b0));
         if (i == 12) chk("accept beats en", key,
            {128'h1415161718191A1B1C1D1E1FDEADBEEF, 128'h000102030405060708090A0B0C0D0E0F});
         if (i == 13) chk("en load", key, {32{8'hA5}});
         if (i == 14) chk("crct load", key, {32{8'h3C}});
      end

      drive(mk(0, 0, 32'h0, 0, 0, 1, 8'h00, 8'h00, 2'b00), "pre-rst clr");
      drive(mk(0, 1, 32'h01234567, 0, 0, 0, 8'h00, 8'h00, 2'b00), "pre-rst a0");
      drive(mk(0, 1, 32'h89ABCDEF, 0, 0, 0, 8'h00, 8'h00, 2'b00), "pre-rst a1");

      rst_n = 1'b0; pif.pdi_valid = 1'b1; en = 1'b1; data_core = {32{8'hEE}};
      #1;
      chk("rst ready", KW'(pif.pdi_ready), KW'(1'b0));
      @(posedge clk);
      #1;
      chk("rst key", key, '0);
      chk("rst full", KW'(full), KW'(2'b00));
      chk("rst done", KW'(done), KW'(1'b0));
      model_reset();
      rst_n = 1'b1;

      drive(mk(0, 1, 32'hAABBCCDD, 0, 0, 0, 8'h00, 8'h00, 2'b00), "post-rst a0");
      drive(mk(0, 1, 32'h11223344, 0, 0, 0, 8'h00, 8'h00, 2'b00), "post-rst a1");
      drive(mk(0, 1, 32'h55667788, 0, 0, 0, 8'h00, 8'h00, 2'b00), "post-rst a2");
      drive(mk(0, 1, 32'h99AABBCC, 0, 0, 0, 8'h00, 8'h00, 2'b01), "post-rst a3");
      chk("refill share0", key, {128'h0, 128'hAABBCCDD112233445566778899AABBCC});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
